// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: owns an HD44780 write-only bus, runs the power-up init sequence,
// then shares the bus round-robin between two req/ack writers with timed E pulses.
module lcd_bus_arbiter #(
  parameter int T_PWRUP     = 1000000,
  parameter int T_SETUP     = 4,
  parameter int T_E_HIGH    = 25,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2500,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       ready,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);
  localparam int M0 = T_PWRUP > T_EXEC_LONG ? T_PWRUP : T_EXEC_LONG;
  localparam int M1 = M0 > T_EXEC ? M0 : T_EXEC;
  localparam int M2 = M1 > T_E_HIGH ? M1 : T_E_HIGH;
  localparam int M3 = M2 > T_SETUP ? M2 : T_SETUP;
  localparam int M4 = M3 > T_HOLD ? M3 : T_HOLD;
  localparam int TW = $clog2(M4 + 1) < 17 ? 17 : $clog2(M4 + 1);
  typedef enum logic [2:0] {PWRUP, SETUP, E_HIGH, HOLD, EXEC, IDLE} state_t;
  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [1:0]      r_init_idx;
  logic            r_last_grant, r_ready, r_busy, r_ack0, r_ack1, r_lcd_e, r_lcd_rs;
  logic [7:0]      r_lcd_data;
  logic            w_long, w_grant0, w_grant1;
  logic [1:0]      w_next_idx;
  logic [7:0]      w_next_byte;
  logic [TW-1:0]   w_exec_last;
  // clear (0x01) and home (0x02/0x03) commands need the long execution wait
  assign w_long      = ~r_lcd_rs & (r_lcd_data[7:2] == 6'd0) & (r_lcd_data[1:0] != 2'd0);
  assign w_exec_last = w_long ? TW'(T_EXEC_LONG - 1) : TW'(T_EXEC - 1);
  assign w_next_idx  = r_init_idx + 2'd1;
  assign w_next_byte = w_next_idx == 2'd1 ? 8'h0C : w_next_idx == 2'd2 ? 8'h06 : 8'h01;
  assign w_grant1    = r_ready & req1 & (~req0 | ~r_last_grant);
  assign w_grant0    = r_ready & req0 & ~w_grant1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= PWRUP;
      r_timer      <= '0;
      r_init_idx   <= '0;
      r_last_grant <= 1'b1;
      r_ready      <= 1'b0;
      r_busy       <= 1'b1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_lcd_e      <= 1'b0;
      r_lcd_rs     <= 1'b0;
      r_lcd_data   <= '0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_timer <= r_timer + TW'(1);
      case (r_state)
        PWRUP: if (r_timer == TW'(T_PWRUP - 1)) begin
          r_state    <= SETUP;
          r_timer    <= '0;
          r_lcd_rs   <= 1'b0;
          r_lcd_data <= 8'h38;
        end
        SETUP: if (r_timer == TW'(T_SETUP - 1)) begin
          r_state <= E_HIGH;
          r_timer <= '0;
          r_lcd_e <= 1'b1;
        end
        E_HIGH: if (r_timer == TW'(T_E_HIGH - 1)) begin
          r_state <= HOLD;
          r_timer <= '0;
          r_lcd_e <= 1'b0;
        end
        HOLD: if (r_timer == TW'(T_HOLD - 1)) begin
          r_state <= EXEC;
          r_timer <= '0;
        end
        EXEC: if (r_timer == w_exec_last) begin
          r_timer <= '0;
          if (r_ready || r_init_idx == 2'd3) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_init_idx <= w_next_idx;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= w_next_byte;
            r_state    <= SETUP;
          end
        end
        IDLE: begin
          r_timer <= '0;
          if (w_grant0 | w_grant1) begin
            r_state      <= SETUP;
            r_busy       <= 1'b1;
            r_lcd_rs     <= w_grant1 ? rs1 : rs0;
            r_lcd_data   <= w_grant1 ? data1 : data0;
            r_last_grant <= w_grant1;
            r_ack0       <= w_grant0;
            r_ack1       <= w_grant1;
          end
        end
        default: r_state <= PWRUP;
      endcase
    end
  end
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign ready    = r_ready;
  assign busy     = r_busy;
  assign lcd_e    = r_lcd_e;
  assign lcd_rw   = 1'b0;
  assign lcd_rs   = r_lcd_rs;
  assign lcd_data = r_lcd_data;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed plus randomized check of lcd_bus_arbiter against a
// transfer-level timing model (each transfer is a start time plus a length).
module tb_lcd_bus_arbiter;
  localparam int PW = 10, S = 2, E = 3, H = 2, X = 5, XL = 20;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, ready, busy, lcd_e, lcd_rw, lcd_rs;
  logic [7:0] lcd_data;
  int n_assert = 0, n_fail = 0;
  int e_rises = 0;
  logic prev_e = 1'b0;
  // reference model: one transfer at a time, described by its elapsed cycles and length
  logic       m_rdy, m_active, m_last, m_ack0, m_ack1, m_rs;
  logic [7:0] m_data;
  int         m_pw, m_t, m_len, m_n_init;
  logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  lcd_bus_arbiter #(.T_PWRUP(PW), .T_SETUP(S), .T_E_HIGH(E), .T_HOLD(H),
                    .T_EXEC(X), .T_EXEC_LONG(XL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .ready(ready), .busy(busy), .lcd_e(lcd_e), .lcd_rw(lcd_rw),
    .lcd_rs(lcd_rs), .lcd_data(lcd_data));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_start(input logic rs, input logic [7:0] d);
    m_active = 1'b1;
    m_t = 0;
    m_rs = rs;
    m_data = d;
    m_len = S + E + H + ((!rs && d >= 8'd1 && d <= 8'd3) ? XL : X);
  endtask

  task automatic model_step();
    logic g;
    if (!rst_n) begin
      m_rdy = 0; m_active = 0; m_last = 1; m_ack0 = 0; m_ack1 = 0;
      m_rs = 0; m_data = 8'h00; m_pw = 0; m_t = 0; m_len = 0; m_n_init = 0;
    end else begin
      m_ack0 = 0;
      m_ack1 = 0;
      if (m_active) begin
        m_t++;
        if (m_t == m_len) begin
          m_active = 0;
          if (!m_rdy) begin
            if (m_n_init == 4) m_rdy = 1;
            else begin m_start(1'b0, init_seq[m_n_init]); m_n_init++; end
          end
        end
      end else if (!m_rdy) begin
        m_pw++;
        if (m_pw == PW) begin m_start(1'b0, init_seq[0]); m_n_init = 1; end
      end else if (req0 || req1) begin
        g = (req0 && req1) ? !m_last : req1;
        if (g) m_start(rs1, data1); else m_start(rs0, data0);
        m_last = g;
        m_ack0 = !g;
        m_ack1 = g;
      end
    end
  endtask

  task automatic check_all();
    chk("lcd_e", lcd_e, m_active && m_t >= S && m_t < S + E);
    chk("lcd_rw", lcd_rw, 1'b0);
    chk("lcd_rs", lcd_rs, m_rs);
    chk("lcd_data", lcd_data, m_data);
    chk("ack0", ack0, m_ack0);
    chk("ack1", ack1, m_ack1);
    chk("ready", ready, m_rdy);
    chk("busy", busy, !m_rdy || m_active);
    chk("ack_exclusive", ack0 & ack1, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (lcd_e && !prev_e) e_rises++;
    prev_e = lcd_e;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || ack0 || ack1) && n < 300) begin tick(); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // one transfer; returns cycles from the grant edge until busy is seen low
  task automatic run_xfer(input logic who, input logic rs, input logic [7:0] d, output int lat);
    int n = 0;
    if (who) begin req1 = 1; rs1 = rs; data1 = d; end
    else begin req0 = 1; rs0 = rs; data0 = d; end
    while (!(who ? ack1 : ack0) && n < 300) begin tick(); n++; end
    chk("xfer_ack", who ? ack1 : ack0, 1'b1);
    req0 = 0;
    req1 = 0;
    lat = 0;
    while (busy && lat < 300) begin tick(); lat++; end
  endtask

  task automatic new_byte(output logic rs, output logic [7:0] d);
    rs = 1'($urandom % 2);
    d = ($urandom % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom % 256);
  endtask

  initial begin
    int n, lat;
    logic exp_g, g;
    logic [7:0] exp_d;
    // reset, with requester 0 already waiting through power-up
    tick(); tick();
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_lcd_e", lcd_e, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    rst_n = 1;
    req0 = 1; rs0 = 1; data0 = 8'h48;
    e_rises = 0;
    n = 0;
    while (!ack0 && n < 300) begin tick(); n++; end
    chk("pending_ack0", ack0, 1'b1);
    chk("ack_after_ready", ready, 1'b1);
    chk("init_pulses", e_rises, 4);
    chk("first_rs", lcd_rs, 1'b1);
    chk("first_data", lcd_data, 8'h48);
    req0 = 0;
    lat = 0;
    while (busy && lat < 300) begin tick(); lat++; end
    chk("short_latency", lat, S + E + H + X);
    // tie: requester 0 was granted last, so alternation begins with requester 1
    tick();
    req0 = 1; rs0 = 1; data0 = 8'hA0;
    req1 = 1; rs1 = 1; data1 = 8'hB0;
    exp_g = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(ack0 || ack1) && n < 300) begin tick(); n++; end
      g = ack1;
      exp_d = exp_g ? data1 : data0;
      chk("tie_order", g, exp_g);
      chk("tie_data", lcd_data, exp_d);
      if (g) data1 = data1 + 8'd1; else data0 = data0 + 8'd1;
      exp_g = !exp_g;
      tick();
    end
    req0 = 0; req1 = 0;
    wait_idle();
    run_xfer(1'b1, 1'b0, 8'h01, lat); chk("clear_long", lat, S + E + H + XL);
    run_xfer(1'b1, 1'b1, 8'h01, lat); chk("data01_short", lat, S + E + H + X);
    run_xfer(1'b0, 1'b0, 8'h03, lat); chk("home03_long", lat, S + E + H + XL);
    run_xfer(1'b0, 1'b0, 8'h04, lat); chk("cmd04_short", lat, S + E + H + X);
    run_xfer(1'b0, 1'b0, 8'h00, lat); chk("cmd00_short", lat, S + E + H + X);
    // random requesters obeying the hold-until-ack protocol
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (ack0) begin if ($urandom % 2 == 0) req0 = 0; else new_byte(rs0, data0); end
      else if (!req0 && $urandom % 8 == 0) begin req0 = 1; new_byte(rs0, data0); end
      if (ack1) begin if ($urandom % 2 == 0) req1 = 0; else new_byte(rs1, data1); end
      else if (!req1 && $urandom % 8 == 0) begin req1 = 1; new_byte(rs1, data1); end
    end
    req0 = 0; req1 = 0;
    wait_idle();
    // reset in the middle of an enable pulse
    req0 = 1; rs0 = 1; data0 = 8'h55;
    n = 0;
    while (!lcd_e && n < 300) begin
      tick(); n++;
      if (ack0) req0 = 0;
    end
    chk("saw_e_high", lcd_e, 1'b1);
    req0 = 0;
    rst_n = 0;
    tick();
    chk("midrst_lcd_e", lcd_e, 1'b0);
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_busy", busy, 1'b1);
    rst_n = 1;
    e_rises = 0;
    n = 0;
    while (!ready && n < 300) begin tick(); n++; end
    chk("reinit_ready", ready, 1'b1);
    chk("reinit_pulses", e_rises, 4);
    tick();
    chk("reinit_idle", busy, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Owns the HD44780-style character LCD bus (E/RW/RS/DB[7:0]) and runs the fixed power-up init sequence.
- After init, shares the bus between two requesters (e.g. status line writer, text writer) using round-robin arbitration and a req/ack handshake.
- Generates every enable pulse with programmable setup, high and hold times.
- Enforces the controller execution time: long for clear/home commands, short for everything else.

Parameters:
- T_PWRUP, 1000000, cycles waited after reset before the first init command (20 ms at 50 MHz).
- T_SETUP, 4, cycles RS/DB are stable with lcd_e low before the E rising edge.
- T_E_HIGH, 25, cycles lcd_e is held high.
- T_HOLD, 4, cycles RS/DB are held after the E falling edge.
- T_EXEC, 2500, post-hold wait for normal commands and data writes (50 us).
- T_EXEC_LONG, 82000, post-hold wait for clear/home commands (1.64 ms).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock domain, reset is synchronous and active-low
- req0  in  1  requester 0 transfer request; held high with rs0/data0 stable until ack0
- rs0  in  1  requester 0 register select (0 = command, 1 = character data)
- data0  in  8  requester 0 byte
- ack0  out  1  one-cycle pulse: requester 0 transfer accepted and latched
- req1, rs1, data1, ack1  same as above, for requester 1
- ready  out  1  high once the init sequence completes; stays high until reset
- busy  out  1  high whenever the FSM is not in IDLE
- lcd_e  out  1  LCD enable
- lcd_rw  out  1  LCD read/write; tied to 0 (write only)
- lcd_rs  out  1  LCD register select
- lcd_data  out  8  LCD data bus

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 sampled at a clk edge), including mid-transfer: state=PWRUP, lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_data=0x00, ack0=ack1=0, ready=0, busy=1, init index=0, last_grant=1, all timers=0.
- States: PWRUP, SETUP, E_HIGH, HOLD, EXEC, IDLE.
- PWRUP: count T_PWRUP cycles, then load init byte 0 with rs=0 and enter SETUP.
- Init bytes, in order: 0x38, 0x0C, 0x06, 0x01.
- SETUP: lcd_e=0 for T_SETUP cycles, then E_HIGH.
- E_HIGH: lcd_e=1 for T_E_HIGH cycles, then HOLD.
- HOLD: lcd_e=0 for T_HOLD cycles, then EXEC.
- lcd_rs and lcd_data are constant from SETUP entry through EXEC exit.
- EXEC wait length: T_EXEC_LONG if latched rs=0 and latched data is 0x01, 0x02 or 0x03; otherwise T_EXEC.
- EXEC exit during init: if more init bytes remain, load the next byte and go to SETUP. After the 4th byte, set ready=1 and go to IDLE.
- EXEC exit after init: go to IDLE.
- IDLE grant rules (evaluated only when ready=1):
  - req0 only: grant 0.
  - req1 only: grant 1.
  - Both requesting: grant the requester opposite to last_grant.
  - First tie after reset therefore goes to requester 0.
- On a grant at a clk edge:
  - latch rs/data of the granted requester into lcd_rs/lcd_data;
  - update last_grant;
  - enter SETUP;
  - pulse the granted ack high for exactly the next cycle.
- Requests during PWRUP/init or while busy are neither acked nor lost; a request stays pending until the requester drops it.
- Requester protocol: may deassert req or present a new byte on the edge after seeing ack. Because the FSM is out of IDLE for at least T_SETUP+T_E_HIGH+T_HOLD+T_EXEC cycles, a held req is never double-captured within one transfer.
- A req still high when the FSM returns to IDLE is treated as a new transfer.
- Per-transfer latency from grant edge to return to IDLE: exactly T_SETUP+T_E_HIGH+T_HOLD+T_EXEC(_LONG) cycles.
- Timers are wide enough for T_EXEC_LONG (minimum 17 bits; size by $clog2 of the largest parameter) and reset to 0 on every state entry.
- lcd_rw is 0 at all times.

Test Plan:
All scenarios use T_PWRUP=10, T_SETUP=2, T_E_HIGH=3, T_HOLD=2, T_EXEC=5, T_EXEC_LONG=20.
- Reset then idle: lcd_e pulses 4 times with lcd_rs=0 and lcd_data 0x38, 0x0C, 0x06, 0x01. Each pulse is 3 cycles high, with 2 setup and 2 hold cycles. The gap after 0x01 is 20 cycles. Then ready=1 and busy=0.
- After ready, req0 with rs0=1, data0=0x48 ('H'): ack0 is a one-cycle pulse; lcd_rs=1, lcd_data=0x48; one 3-cycle E pulse; busy falls 12 cycles after the grant edge.
- req0 and req1 asserted in the same cycle and both held: grants alternate 0,1,0,1. ack0 and ack1 are never high together. Each transfer's lcd_data matches its granted requester.
- req1 with rs1=0, data1=0x01: EXEC lasts 20 cycles. With rs1=1, data1=0x01, EXEC lasts 5 cycles.
- req0 asserted during PWRUP: no ack0 until ready=1. The first transfer after init is the pending 0x48.
- rst_n=0 for 1 cycle while lcd_e=1: next edge gives lcd_e=0, ready=0, busy=1, state=PWRUP. The full init sequence repeats.
